tx_gearbox_130to32: RTL and testbench
=====================================

TX_GEARBOX_130TO32 -- requirements
Module: tx_gearbox_130to32

Interface
REQ-001 SHALL have parameter: OUT_W, 32, output word width in bits; supported values 32 and 64 only.
REQ-002 SHALL have derived constant: CAP = 130 + 2*OUT_W, buffer capacity in bits (194 for OUT_W=32).
REQ-003 SHALL have port: clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port: block_in  input  130  framed block; [129:128] sync header, [127:0] payload.
REQ-006 SHALL have port: block_valid  input  1  block_in holds a block.
REQ-007 SHALL have port: block_ready  output  1  gearbox accepts block_in this cycle.
REQ-008 SHALL have port: data_out  output  OUT_W  serialized word; bit 0 is the earliest bit on the wire.
REQ-009 SHALL have port: data_valid  output  1  data_out holds OUT_W valid bits.
REQ-010 SHALL have port: data_ready  input  1  downstream consumes data_out this cycle.
REQ-011 SHALL have port: blk_cnt  output  16  count of accepted blocks, wraps modulo 2^16.
REQ-012 SHALL have port: hdr_err  output  1  invalid sync header flag (see Configuration).

Function
REQ-013 Wire order SHALL be block_in[129] first, then [128], down to block_in[0] last.
REQ-014 The block SHALL hold a bit buffer with occupancy count (0..CAP).
REQ-015 block_ready SHALL be 1 exactly when count <= 2*OUT_W; it SHALL NOT depend combinationally on data_ready or block_valid.
REQ-016 A block SHALL be accepted when block_valid && block_ready; its 130 bits SHALL be appended behind all buffered bits.
REQ-017 data_valid SHALL be 1 exactly when count >= OUT_W; data_out SHALL be the oldest OUT_W buffered bits.
REQ-018 When data_valid && data_ready, the oldest OUT_W bits SHALL be removed at the clock edge.
REQ-019 With simultaneous accept and pop, next count SHALL be count + 130 - OUT_W, and the appended bits SHALL follow the remaining bits without gaps or duplication.
REQ-020 A block accepted at edge N SHALL make its first bit visible on data_out at the earliest after edge N; with an empty buffer, data_valid SHALL rise in the cycle after edge N.
REQ-021 While data_valid && !data_ready, data_out and count SHALL hold stable.
REQ-022 With block_valid held high and data_ready held high, data_valid SHALL stay 1 every cycle after the first word (no bubbles).
REQ-023 With no input, the residual bits below OUT_W SHALL remain buffered; data_valid SHALL stay 0 and no padding SHALL be inserted.
REQ-024 blk_cnt SHALL increment by 1 on each accepted block and wrap 0xFFFF -> 0x0000.

Reset
REQ-025 rst_n low SHALL asynchronously clear count, buffer contents, and blk_cnt to 0, and clear hdr_err to 0.
REQ-026 During reset, block_ready SHALL be 1 (count=0), data_valid SHALL be 0, and data_out SHALL be 0.
REQ-027 Reset asserted mid-stream SHALL discard all buffered bits; the first word after release SHALL come only from blocks accepted after release.

Configuration
REQ-028 Macro GEARBOX_HDR_CHECK_EN defined: hdr_err SHALL be registered and SHALL pulse high for one cycle after the edge that accepts a block whose block_in[129:128] is 2'b00 or 2'b11; the block SHALL still be forwarded unchanged.
REQ-029 Macro GEARBOX_HDR_CHECK_EN undefined: hdr_err SHALL be constant 0, and no header-check logic SHALL be present.

Verification
REQ-030 Bench SHALL cover: reset release, send one block {2'b01, 128'h0}, data_ready=1 -> 4 words with data_valid=1; word0 bit0=0, bit1=1, other bits 0; count=2 remains; block_ready=1.
REQ-031 Bench SHALL cover: block_valid=1 held with 65 distinct random blocks, data_ready=1 -> the concatenated words equal the concatenated blocks bit-exact (8450 bits = 264 words + 2 residual bits), data_valid has no gaps after the first word, and blk_cnt=65.
REQ-032 Bench SHALL cover: data_ready=0 for 10 cycles mid-stream -> data_out stable, block_ready falls once count > 64, no bits are lost after data_ready returns to 1.
REQ-033 Bench SHALL cover: rst_n pulsed low asynchronously between edges with count=98 -> data_valid=0 and count=0 immediately; the next block's header bits appear at word0 bits 0-1.
REQ-034 Bench SHALL cover: with GEARBOX_HDR_CHECK_EN, block header 2'b11 accepted -> hdr_err=1 for exactly one cycle and data forwarded; without the macro, hdr_err=0 throughout.
REQ-035 Bench SHALL cover: 65536 blocks accepted -> blk_cnt reads 0x0000.

Source files
------------

// File: rtl/tx_gearbox_130to32.sv
// Serializes 130-bit framed blocks into OUT_W-bit words; data_out[0] is the earliest wire bit.
// Define GEARBOX_HDR_CHECK_EN to flag accepted blocks with sync header 2'b00/2'b11 on hdr_err.
module tx_gearbox_130to32 #(
   parameter int OUT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [129:0]     block_in,
   input  logic             block_valid,
   output logic             block_ready,
   output logic [OUT_W-1:0] data_out,
   output logic             data_valid,
   input  logic             data_ready,
   output logic [15:0]      blk_cnt,
   output logic             hdr_err
);

   localparam int BLK_W = 130;
   localparam int CAP   = BLK_W + 2*OUT_W;
   localparam int CW    = $clog2(CAP + 1);

   localparam logic [CW-1:0] C_OUT  = CW'(OUT_W);
   localparam logic [CW-1:0] C_2OUT = CW'(2*OUT_W);
   localparam logic [CW-1:0] C_BLK  = CW'(BLK_W);

   // r_buf[0] is the oldest buffered bit; bits at and above r_count are always zero
   logic [CAP-1:0]   r_buf;
   logic [CW-1:0]    r_count;
   logic [15:0]      r_blk_cnt;

   logic             w_accept;
   logic             w_pop;
   logic [BLK_W-1:0] w_rev;
   logic [CW-1:0]    w_base;
   logic [CW-1:0]    w_count_nxt;
   logic [CAP-1:0]   w_kept;
   logic [CAP-1:0]   w_ins;
   logic [CAP-1:0]   w_buf_nxt;

   assign block_ready = (r_count <= C_2OUT);
   assign data_valid  = (r_count >= C_OUT);
   assign w_accept    = block_valid & block_ready;
   assign w_pop       = data_valid & data_ready;
   assign data_out    = data_valid ? r_buf[OUT_W-1:0] : '0;
   assign blk_cnt     = r_blk_cnt;

   // Reverse the block so block_in[129] lands at the lowest (earliest) free position
   always_comb begin
      w_rev = '0;
      for (int i = 0; i < BLK_W; i++) begin
         w_rev[i] = block_in[BLK_W-1-i];
      end
   end

   always_comb begin
      w_kept      = w_pop ? (r_buf >> OUT_W) : r_buf;
      w_base      = w_pop ? (r_count - C_OUT) : r_count;
      w_ins       = w_accept ? ({{(CAP-BLK_W){1'b0}}, w_rev} << w_base) : '0;
      w_buf_nxt   = w_kept | w_ins;
      w_count_nxt = r_count + (w_accept ? C_BLK : '0) - (w_pop ? C_OUT : '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_buf     <= '0;
         r_count   <= '0;
         r_blk_cnt <= '0;
      end else begin
         r_buf   <= w_buf_nxt;
         r_count <= w_count_nxt;
         if (w_accept) begin
            r_blk_cnt <= r_blk_cnt + 16'd1;
         end
      end
   end

`ifdef GEARBOX_HDR_CHECK_EN
   logic r_hdr_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hdr_err <= 1'b0;
      end else begin
         r_hdr_err <= w_accept & (block_in[129] == block_in[128]);
      end
   end

   assign hdr_err = r_hdr_err;
`else
   assign hdr_err = 1'b0;
`endif

endmodule

// File: tb/tb_tx_gearbox_130to32.sv
// Bench for tx_gearbox_130to32: bit-queue reference model, per-cycle compare and directed scenarios.
module tb_tx_gearbox_130to32;

   localparam int W = 32;
`ifdef GEARBOX_HDR_CHECK_EN
   localparam bit HDR_EN = 1'b1;
`else
   localparam bit HDR_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic [129:0]  block_in;
   logic          block_valid;
   logic          block_ready;
   logic [W-1:0]  data_out;
   logic          data_valid;
   logic          data_ready;
   logic [15:0]   blk_cnt;
   logic          hdr_err;

   int checks   = 0;
   int failures = 0;

   tx_gearbox_130to32 #(.OUT_W(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .block_in    (block_in),
      .block_valid (block_valid),
      .block_ready (block_ready),
      .data_out    (data_out),
      .data_valid  (data_valid),
      .data_ready  (data_ready),
      .blk_cnt     (blk_cnt),
      .hdr_err     (hdr_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: the wire as a queue of bits, oldest at index 0
   bit          mq[$];
   int unsigned m_cnt;
   bit          m_hdr;
   bit          m_acc;
   bit          m_pop;

   initial begin
      m_cnt = 0;
      m_hdr = 1'b0;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            mq.delete();
            m_cnt = 0;
            m_hdr = 1'b0;
         end else begin
            m_acc = block_valid && (mq.size() <= 2*W);
            m_pop = data_ready && (mq.size() >= W);
            if (m_pop) repeat (W) void'(mq.pop_front());
            if (m_acc) begin
               for (int i = 129; i >= 0; i--) mq.push_back(block_in[i]);
               m_cnt = (m_cnt + 1) % 65536;
            end
            m_hdr = HDR_EN && m_acc && (block_in[129] == block_in[128]);
         end
      end
   end

   // Per-cycle comparison against the model, away from the active edge
   initial begin
      logic [W-1:0] exp_w;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            check("data_valid", 64'(data_valid), 64'(mq.size() >= W));
            check("block_ready", 64'(block_ready), 64'(mq.size() <= 2*W));
            if (mq.size() >= W) begin
               for (int i = 0; i < W; i++) exp_w[i] = mq[i];
               check("data_out", 64'(data_out), 64'(exp_w));
            end
            check("blk_cnt", 64'(blk_cnt), 64'(m_cnt[15:0]));
            check("hdr_err", 64'(hdr_err), 64'(m_hdr));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   logic [129:0] blks[$];
   bit           sq[$];
   bit           rq[$];
   logic [W-1:0] wq[$];

   task automatic do_reset();
      rst_n       = 1'b0;
      block_valid = 1'b0;
      block_in    = '0;
      data_ready  = 1'b0;
      #1;
      check("rst_data_valid", 64'(data_valid), 64'(0));
      check("rst_block_ready", 64'(block_ready), 64'(1));
      check("rst_data_out", 64'(data_out), 64'(0));
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
   endtask

   // Streams blks[0..nblk-1]; optional stall window; collects popped words into rq/wq
   task automatic run_stream(input int nblk, input int stall_at, input int stall_len,
                             input bit chk_gap);
      int idx = 0;
      int cyc = 0;
      int gaps = 0;
      int nwords = 0;
      int expw;
      int mism = 0;
      bit started = 1'b0;
      logic [W-1:0] held = '0;
      sq.delete(); rq.delete(); wq.delete();
      for (int b = 0; b < nblk; b++)
         for (int i = 129; i >= 0; i--) sq.push_back(blks[b][i]);
      expw = (nblk * 130) / W;
      while (nwords < expw && cyc < 5000) begin
         block_valid = (idx < nblk);
         block_in    = (idx < nblk) ? blks[idx] : '0;
         data_ready  = !(stall_at >= 0 && cyc >= stall_at && cyc < stall_at + stall_len);
         @(negedge clk);
         if (!data_ready) begin
            if (cyc == stall_at) held = data_out;
            else check("stall_hold", 64'(data_out), 64'(held));
            if (cyc == stall_at + stall_len - 1)
               check("stall_ready_low", 64'(block_ready), 64'(0));
         end
         if (data_valid) started = 1'b1;
         else if (started && chk_gap) gaps++;
         if (data_valid && data_ready) begin
            for (int i = 0; i < W; i++) rq.push_back(data_out[i]);
            wq.push_back(data_out);
            nwords++;
         end
         if (block_valid && mq.size() <= 2*W) idx++;
         @(posedge clk);
         #2;
         cyc++;
      end
      block_valid = 1'b0;
      block_in    = '0;
      data_ready  = 1'b1;
      check("words_recv", 64'(nwords), 64'(expw));
      for (int i = 0; i < rq.size(); i++) if (rq[i] != sq[i]) mism++;
      check("stream_bits", 64'(mism), 64'(0));
      if (chk_gap) check("no_bubble", 64'(gaps), 64'(0));
   endtask

   initial begin
      logic [129:0] b;

      // Single block with header 01, zero payload
      do_reset();
      blks.delete();
      blks.push_back({2'b01, 128'h0});
      run_stream(1, -1, 0, 1'b0);
      check("t1_words", 64'(wq.size()), 64'(4));
      if (wq.size() == 4) begin
         check("t1_word0", 64'(wq[0]), 64'(32'h0000_0002));
         check("t1_word1", 64'(wq[1]), 64'(0));
         check("t1_word2", 64'(wq[2]), 64'(0));
         check("t1_word3", 64'(wq[3]), 64'(0));
      end
      repeat (3) @(posedge clk);
      #2;
      check("t1_residual", 64'(mq.size()), 64'(2));
      check("t1_valid_low", 64'(data_valid), 64'(0));
      check("t1_ready", 64'(block_ready), 64'(1));

      // 65 random blocks back to back
      do_reset();
      blks.delete();
      for (int k = 0; k < 65; k++) begin
         b = {2'($urandom_range(3, 0)), $urandom(), $urandom(), $urandom(), $urandom()};
         blks.push_back(b);
      end
      run_stream(65, -1, 0, 1'b1);
      check("t2_blk_cnt", 64'(blk_cnt), 64'(65));
      check("t2_residual", 64'(mq.size()), 64'(2));

      // Downstream stall for 10 cycles mid-stream
      do_reset();
      blks.delete();
      for (int k = 0; k < 10; k++) begin
         b = {2'b10, $urandom(), $urandom(), $urandom(), $urandom()};
         blks.push_back(b);
      end
      run_stream(10, 12, 10, 1'b0);

      // Asynchronous reset with 98 bits buffered
      do_reset();
      block_in    = {2'b01, 128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000};
      block_valid = 1'b1;
      data_ready  = 1'b1;
      @(posedge clk); #2;
      block_valid = 1'b0;
      @(posedge clk); #2;
      data_ready  = 1'b0;
      #1;
      check("t4_count98", 64'(mq.size()), 64'(98));
      check("t4_valid_pre", 64'(data_valid), 64'(1));
      rst_n = 1'b0;
      #1;
      check("t4_async_valid", 64'(data_valid), 64'(0));
      check("t4_async_ready", 64'(block_ready), 64'(1));
      check("t4_async_dout", 64'(data_out), 64'(0));
      check("t4_async_blkcnt", 64'(blk_cnt), 64'(0));
      @(posedge clk); #2;
      rst_n = 1'b1;
      blks.delete();
      blks.push_back({2'b10, 128'h0});
      run_stream(1, -1, 0, 1'b0);
      if (wq.size() > 0) check("t4_word0", 64'(wq[0]), 64'(32'h0000_0001));

      // Header 2'b11 block
      do_reset();
      block_in    = {2'b11, 128'h5};
      block_valid = 1'b1;
      data_ready  = 1'b1;
      @(posedge clk); #2;
      block_valid = 1'b0;
      @(negedge clk);
      check("t5_hdr_pulse", 64'(hdr_err), 64'(HDR_EN));
      check("t5_valid", 64'(data_valid), 64'(1));
      check("t5_word0", 64'(data_out), 64'(32'h0000_0003));
      @(posedge clk); #2;
      @(negedge clk);
      check("t5_hdr_clear", 64'(hdr_err), 64'(0));
      repeat (5) @(posedge clk);
      #2;

      // Counter wrap: preload near 0xFFFF, then two blocks
      do_reset();
      force dut.r_blk_cnt = 16'hFFFE;
      m_cnt = 32'hFFFE;
      #1;
      release dut.r_blk_cnt;
      #1;
      check("t6_preload", 64'(blk_cnt), 64'(16'hFFFE));
      @(posedge clk); #2;
      blks.delete();
      blks.push_back({2'b01, 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321});
      blks.push_back({2'b10, 128'hA5A5_5A5A_0000_FFFF_1111_2222_3333_4444});
      run_stream(2, -1, 0, 1'b0);
      check("t6_wrap", 64'(blk_cnt), 64'(16'h0000));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
